// File: rtl/fpmul_arb.sv
// fpmul_arb: round-robin arbiter sharing one FP multiplier between two requesters.
// Define FPMUL_ARB_TIMEOUT_EN to build the WAIT-state watchdog (abort after TIMEOUT cycles).
module fpmul_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req0,
  input  logic [31:0] A0,
  input  logic [31:0] B0,
  input  logic        Req1,
  input  logic [31:0] A1,
  input  logic [31:0] B1,
  output logic        Gnt0,
  output logic        Gnt1,
  output logic        Ack0,
  output logic        Ack1,
  output logic [31:0] P,
  output logic [5:0]  Flags,
  output logic        Err,
  output logic        M_Start,
  output logic [31:0] M_A,
  output logic [31:0] M_B,
  input  logic        M_Done,
  input  logic [31:0] M_P,
  input  logic [5:0]  M_Flags
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [31:0] QNAN_P     = 32'h7FC0_0000;
  localparam logic [5:0]  QNAN_FLAGS = 6'b001000;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("fpmul_arb: TIMEOUT must lie in 2..255");
  end

  state_e      state_q, state_d;
  logic        owner_q;
  logic        last_q;
  logic        first_q;
  logic [31:0] m_a_q, m_b_q, p_q;
  logic [5:0]  flags_q;
  logic        pick;
  logic        accept;
  logic        done_hit;
  logic        timeout_hit;

  // Requester 1 wins alone or on a tie when requester 0 was served last.
  assign pick     = (Req0 && Req1) ? ~last_q : Req1;
  assign accept   = (state_q == IDLE) && (Req0 || Req1);
  // The first WAIT cycle may still show Done from the previous operation.
  assign done_hit = (state_q == WAIT) && !first_q && M_Done;

`ifdef FPMUL_ARB_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wd_cnt_q;
  logic       err_q;

  assign timeout_hit = (state_q == WAIT) && !done_hit && (wd_cnt_q == WD_LAST);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wd_cnt_q <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= (state_q == WAIT) ? wd_cnt_q + 8'd1 : 8'd0;
      if (done_hit) begin
        err_q <= 1'b0;
      end else if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign Err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign Err         = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (done_hit || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    M_Start = (state_q == ISSUE);
    Gnt0    = (state_q == ISSUE) && !owner_q;
    Gnt1    = (state_q == ISSUE) &&  owner_q;
    Ack0    = (state_q == RESP)  && !owner_q;
    Ack1    = (state_q == RESP)  &&  owner_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      first_q <= 1'b0;
      m_a_q   <= 32'h0;
      m_b_q   <= 32'h0;
      p_q     <= 32'h0;
      flags_q <= 6'h0;
    end else begin
      first_q <= (state_q == ISSUE);
      if (accept) begin
        owner_q <= pick;
        m_a_q   <= pick ? A1 : A0;
        m_b_q   <= pick ? B1 : B0;
      end
      if (done_hit) begin
        p_q     <= M_P;
        flags_q <= M_Flags;
      end else if (timeout_hit) begin
        p_q     <= QNAN_P;
        flags_q <= QNAN_FLAGS;
      end
      if (state_q == RESP) begin
        last_q <= owner_q;
      end
    end
  end

  assign M_A   = m_a_q;
  assign M_B   = m_b_q;
  assign P     = p_q;
  assign Flags = flags_q;

endmodule
